mult_ctrl: RTL and testbench
============================

// Module: mult_ctrl
// PURPOSE
//  Issue/sequence controller for the pipelined radix-4 Booth + Wallace multiplier core.
//  Accepts one multiply request at a time from the EX stage over a valid/ready handshake.
//  Extends operands for signed/unsigned mode, launches the core and counts its fixed latency.
//  Captures the 2*DATA_W product and holds it until writeback accepts it; pipeline flush aborts it.
// PARAMETERS
//  DATA_W    32  operand width; product is 2*DATA_W
//  PIPE_LAT  2   core latency in cycles, core_start to core_prod valid; legal range 1..15
// PORTS
//  clk         in   1          clock, rising edge
//  resetn      in   1          asynchronous active-low reset
//  req_valid   in   1          request present
//  req_ready   out  1          controller can accept a request this cycle
//  req_signed  in   1          1 = mult (signed), 0 = multu (unsigned)
//  req_x       in   DATA_W     multiplicand
//  req_y       in   DATA_W     multiplier
//  flush       in   1          abort any op in flight (exception/ERET)
//  core_start  out  1          one-cycle launch pulse to the core
//  core_x      out  DATA_W+1   extended multiplicand to the core
//  core_y      out  DATA_W+1   extended multiplier to the core
//  core_prod   in   2*DATA_W   core product, valid exactly PIPE_LAT cycles after core_start
//  res_valid   out  1          product held and valid
//  res_ready   in   1          writeback accepts the product
//  res_prod    out  2*DATA_W   {hi, lo} product
//  busy        out  1          state != IDLE (used for HI/LO interlock)
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE, cnt=0, core_start=0, core_x=0, core_y=0,
//   res_valid=0, res_prod=0; busy=0; req_ready=1 once resetn is high.
//  States: IDLE, BUSY, DONE (2-bit). cnt is a 4-bit down-counter.
//  Accept = req_valid & req_ready. req_ready = !flush & (IDLE | (DONE & res_ready)).
//  On accept (registered, next edge): state->BUSY, cnt=PIPE_LAT-1, core_start=1 for one cycle.
//   core_x = {req_signed & req_x[DATA_W-1], req_x}; same rule for core_y.
//   core_x/core_y hold their values until the next accept.
//  BUSY: cnt decrements each cycle. Capture condition is cnt==0 and core_start==0.
//   On capture: res_prod<=core_prod, res_valid<=1, state->DONE.
//   Latency from accept edge to res_valid high is PIPE_LAT+1 cycles.
//  DONE: res_prod and res_valid are stable until res_ready=1.
//   res_ready=1 without a new accept: res_valid->0, state->IDLE.
//   res_ready=1 with a same-cycle accept: back-to-back; state->BUSY and res_valid->0 next edge.
//  flush=1 (any state, synchronous): next edge state->IDLE, res_valid->0, cnt->0, core_start->0.
//   A request presented with flush is never accepted. A core result still in flight is ignored.
//   res_prod keeps its old value.
//  A res_ready=1 in the same cycle as flush=1 is a discard, not a handshake.
//  res_ready has no effect in IDLE or BUSY. req_* are ignored unless Accept is true.
//  There is never more than one op in the core, so no result tagging is needed.
//  busy = (state != IDLE), a combinational decode of the state register.
// TESTING
//  Test benches use a behavioural core model: a PIPE_LAT-deep pipeline of signed 33x33 multiply, truncated to 64 bits.
//  T1 signed: x=0xFFFFFFFF, y=0x00000002, signed=1 -> core_x=0x1FFFFFFFF; res_valid 3 cycles after accept;
//   res_prod=0xFFFFFFFF_FFFFFFFE.
//  T2 unsigned: x=y=0xFFFFFFFF, signed=0 -> core_x=0x0FFFFFFFF; res_prod=0xFFFFFFFE_00000001.
//  T3 backpressure: res_ready=0 for 10 cycles after res_valid -> res_prod stable, req_ready=0, busy=1.
//   Then res_ready=1 -> IDLE.
//  T4 back-to-back: 7*6 and -3*5 signed, second request held valid with res_ready=1 ->
//   second accepted in the same cycle the first result retires; products 42 then 0xFFFFFFFF_FFFFFFF1.
//  T5 flush: flush one cycle after accept (BUSY) -> IDLE next edge, res_valid never rises,
//   and the stale core output at the capture time is ignored. Repeat the flush in DONE -> res_valid drops.
//  T6 reset mid-op: assert resetn=0 asynchronously while BUSY -> all outputs at reset values immediately.
//   After release, a new 3*4 request returns 12.

Source files
------------

// File: rtl/mult_ctrl.sv
// mult_ctrl: issue/sequence controller for the pipelined radix-4 Booth +
// Wallace multiplier core. It accepts one request at a time and extends the
// operands for signed or unsigned mode. It launches the core, counts the
// core's fixed latency, then captures the product and holds it until
// writeback takes it. A flush aborts whatever is in flight.
//
// Ports:
//   clk, resetn              clock (rising edge), async active-low reset
//   req_valid/req_ready      request handshake from EX
//   req_signed, req_x, req_y request mode and operands
//   flush                    abort any op in flight
//   core_start               one-cycle launch pulse to the core
//   core_x, core_y           DATA_W+1 extended operands to the core
//   core_prod                core product, valid PIPE_LAT cycles after core_start
//   res_valid/res_ready      result handshake to writeback
//   res_prod                 {hi, lo} product
//   busy                     controller not idle (HI/LO interlock)
module mult_ctrl #(
  parameter int DATA_W   = 32,
  parameter int PIPE_LAT = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_signed,
  input  logic [DATA_W-1:0]     req_x,
  input  logic [DATA_W-1:0]     req_y,
  input  logic                  flush,
  output logic                  core_start,
  output logic [DATA_W:0]       core_x,
  output logic [DATA_W:0]       core_y,
  input  logic [2*DATA_W-1:0]   core_prod,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*DATA_W-1:0]   res_prod,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(PIPE_LAT - 1);

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  cnt_r;
  logic        accept_s;
  logic        capture_s;

  // Extend an operand to DATA_W+1 bits: sign bit in signed mode, zero otherwise.
  function automatic logic [DATA_W:0] ext_operand(input logic sgn, input logic [DATA_W-1:0] v);
    return {sgn & v[DATA_W-1], v};
  endfunction

  // A request can be taken when idle, or when the held result retires this same cycle.
  assign req_ready = !flush && ((state_r == IDLE) || ((state_r == DONE) && res_ready));
  assign accept_s  = req_valid && req_ready;
  assign busy      = (state_r != IDLE);

  // The launch cycle does not count. This makes the capture land PIPE_LAT+1 edges after accept.
  assign capture_s = (state_r == BUSY) && (cnt_r == 4'd0) && !core_start;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; flush overrides everything, including a res_ready handshake.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_next_s = BUSY;
          end else begin
            state_next_s = IDLE;
          end
        end
        BUSY: begin
          if (capture_s) begin
            state_next_s = DONE;
          end else begin
            state_next_s = BUSY;
          end
        end
        DONE: begin
          if (accept_s) begin
            state_next_s = BUSY;
          end else if (res_ready) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DONE;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // Latency counter, launch pulse, operand registers and result holding register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r      <= 4'd0;
      core_start <= 1'b0;
      core_x     <= {(DATA_W+1){1'b0}};
      core_y     <= {(DATA_W+1){1'b0}};
      res_valid  <= 1'b0;
      res_prod   <= {(2*DATA_W){1'b0}};
    end else begin
      core_start <= 1'b0;
      if (flush) begin
        // res_prod deliberately keeps its old value; only the valid flag is dropped.
        cnt_r     <= 4'd0;
        res_valid <= 1'b0;
      end else if (accept_s) begin
        cnt_r      <= CNT_INIT;
        core_start <= 1'b1;
        core_x     <= ext_operand(req_signed, req_x);
        core_y     <= ext_operand(req_signed, req_y);
        res_valid  <= 1'b0;
      end else if (capture_s) begin
        res_prod  <= core_prod;
        res_valid <= 1'b1;
      end else begin
        if ((state_r == BUSY) && (cnt_r != 4'd0) && !core_start) begin
          cnt_r <= cnt_r - 4'd1;
        end else begin
          cnt_r <= cnt_r;
        end
        if ((state_r == DONE) && res_ready) begin
          res_valid <= 1'b0;
        end else begin
          res_valid <= res_valid;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl. It uses a behavioural core made of a PIPE_LAT-deep
// pipeline of signed 33x33 multiplies. Expected products come from hand
// constants and from a scoreboard queue that is filled at request acceptance.
module tb_mult_ctrl;

  localparam int DW  = 32;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_signed = 1'b0;
  logic [DW-1:0]   req_x = '0;
  logic [DW-1:0]   req_y = '0;
  logic            flush = 1'b0;
  logic            core_start;
  logic [DW:0]     core_x;
  logic [DW:0]     core_y;
  logic [2*DW-1:0] core_prod;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [2*DW-1:0] res_prod;
  logic            busy;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb_q[$];

  mult_ctrl #(.DATA_W(DW), .PIPE_LAT(LAT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_x(req_x), .req_y(req_y), .flush(flush),
    .core_start(core_start), .core_x(core_x), .core_y(core_y), .core_prod(core_prod),
    .res_valid(res_valid), .res_ready(res_ready), .res_prod(res_prod), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural core: free-running multiply pipeline.
  logic [63:0] core_pipe [LAT];
  function automatic logic [63:0] core_mul(input logic [32:0] a, input logic [32:0] b);
    logic signed [65:0] p;
    p = $signed(a) * $signed(b);
    return p[63:0];
  endfunction
  always @(posedge clk) begin
    core_pipe[0] <= core_mul(core_x, core_y);
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_prod = core_pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference product computed directly from the 32-bit operands.
  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sp;
    if (sgn) begin
      sp = $signed(x) * $signed(y);
      return sp;
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Scoreboard: push on accept, pop on result handshake, discard on flush.
  always @(posedge clk) begin
    if (resetn) begin
      if (flush) begin
        sb_q.delete();
      end else begin
        if (res_valid && res_ready) begin
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
          end else begin
            chk("sb_prod", res_prod, sb_q.pop_front());
          end
        end
        if (req_valid && req_ready) sb_q.push_back(ref_mul(req_signed, req_x, req_y));
      end
    end
  end
  always @(negedge resetn) sb_q.delete();

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
      if (n == 1) chk("core_start_pulse", {63'd0, core_start}, 64'd0);
    end
  endtask

  // One complete operation: request, launch checks, latency, product, retire.
  task automatic run_op(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                        input logic [32:0] cx, input logic [32:0] cy, input logic [63:0] prod);
    int n;
    req_valid = 1'b1; req_signed = sgn; req_x = x; req_y = y;
    #1 chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
    chk("core_start", {63'd0, core_start}, 64'd1);
    chk("core_x", {31'd0, core_x}, {31'd0, cx});
    chk("core_y", {31'd0, core_y}, {31'd0, cy});
    chk("busy_run", {63'd0, busy}, 64'd1);
    wait_valid(n);
    chk("latency", 64'(n), 64'(LAT + 1));
    chk("res_prod", res_prod, prod);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("retire_valid", {63'd0, res_valid}, 64'd0);
    chk("retire_busy", {63'd0, busy}, 64'd0);
  endtask

  typedef struct {
    logic        sgn;
    logic [31:0] x;
    logic [31:0] y;
    logic [32:0] cx;
    logic [32:0] cy;
    logic [63:0] prod;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int n;
    logic [63:0] held;
    vecs[0] = '{1'b1, 32'hFFFFFFFF, 32'h00000002, 33'h1FFFFFFFF, 33'h000000002, 64'hFFFFFFFF_FFFFFFFE};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h0FFFFFFFF, 33'h0FFFFFFFF, 64'hFFFFFFFE_00000001};
    vecs[2] = '{1'b1, 32'h00000007, 32'h00000006, 33'h000000007, 33'h000000006, 64'd42};
    vecs[3] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 33'h1FFFFFFFD, 33'h000000005, 64'hFFFFFFFF_FFFFFFF1};
    vecs[4] = '{1'b1, 32'h80000000, 32'h80000000, 33'h180000000, 33'h180000000, 64'h40000000_00000000};
    vecs[5] = '{1'b0, 32'h80000000, 32'h00000002, 33'h080000000, 33'h000000002, 64'h00000001_00000000};
    vecs[6] = '{1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 33'h07FFFFFFF, 33'h1FFFFFFFF, 64'hFFFFFFFF_80000001};

    // Reset state.
    #3;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_core_start", {63'd0, core_start}, 64'd0);
    chk("rst_core_x", {31'd0, core_x}, 64'd0);
    chk("rst_res_prod", res_prod, 64'd0);
    #20 resetn = 1'b1;
    step();
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Table-driven operations (T1, T2 and boundary operands).
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].sgn, vecs[i].x, vecs[i].y, vecs[i].cx, vecs[i].cy, vecs[i].prod);
    end

    // T3: backpressure holds the result; a pending request is refused.
    req_valid = 1'b1; req_signed = 1'b1; req_x = 32'd1000; req_y = 32'd1000;
    step();
    req_valid = 1'b0;
    wait_valid(n);
    chk("bp_prod", res_prod, 64'd1000000);
    held = res_prod;
    req_valid = 1'b1; req_x = 32'd9; req_y = 32'd9;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_stable", res_prod, held);
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
      chk("bp_busy", {63'd0, busy}, 64'd1);
      chk("bp_valid", {63'd0, res_valid}, 64'd1);
      step();
    end
    req_valid = 1'b0; res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_idle", {63'd0, busy}, 64'd0);
    chk("bp_retired", {63'd0, res_valid}, 64'd0);

    // T4: back-to-back, second accepted in the same cycle the first retires.
    req_valid = 1'b1; req_signed = 1'b1; req_x = 32'd7; req_y = 32'd6;
    step();
    req_valid = 1'b0;
    wait_valid(n);
    chk("b2b_first", res_prod, 64'd42);
    req_valid = 1'b1; req_x = 32'hFFFFFFFD; req_y = 32'd5; res_ready = 1'b1;
    #1 chk("b2b_req_ready", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0; res_ready = 1'b0;
    chk("b2b_start", {63'd0, core_start}, 64'd1);
    chk("b2b_valid_drop", {63'd0, res_valid}, 64'd0);
    chk("b2b_core_x", {31'd0, core_x}, 64'h1FFFFFFFD);
    wait_valid(n);
    chk("b2b_latency", 64'(n), 64'(LAT + 1));
    chk("b2b_second", res_prod, 64'hFFFFFFFF_FFFFFFF1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // T5a: flush in BUSY; request presented with flush is refused, stale core output ignored.
    req_valid = 1'b1; req_signed = 1'b0; req_x = 32'd9; req_y = 32'd9;
    step();
    flush = 1'b1; req_x = 32'd11;
    #1 chk("flush_req_ready", {63'd0, req_ready}, 64'd0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_start", {63'd0, core_start}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      chk("flush_no_valid", {63'd0, res_valid}, 64'd0);
      step();
    end

    // T5b: flush in DONE with res_ready is a discard; res_prod keeps old value.
    req_valid = 1'b1; req_signed = 1'b1; req_x = 32'd2; req_y = 32'd3;
    step();
    req_valid = 1'b0;
    wait_valid(n);
    chk("flushd_prod", res_prod, 64'd6);
    flush = 1'b1; res_ready = 1'b1;
    step();
    flush = 1'b0; res_ready = 1'b0;
    chk("flushd_valid", {63'd0, res_valid}, 64'd0);
    chk("flushd_busy", {63'd0, busy}, 64'd0);
    chk("flushd_keep", res_prod, 64'd6);

    // T6: asynchronous reset while BUSY, then a fresh 3*4.
    req_valid = 1'b1; req_x = 32'd5; req_y = 32'd5;
    step();
    req_valid = 1'b0;
    step();
    #1 resetn = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_valid", {63'd0, res_valid}, 64'd0);
    chk("arst_core_x", {31'd0, core_x}, 64'd0);
    chk("arst_res_prod", res_prod, 64'd0);
    #1 resetn = 1'b1;
    step();
    run_op(1'b1, 32'd3, 32'd4, 33'd3, 33'd4, 64'd12);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
